mem_block_mover: RTL

- Bus initiator for the 256x8 data memory.
- Drives the memory's write enable, address and write data, and samples its combinational read data.
- Performs block copy (memory to memory) or block fill (constant to memory) on request from the CPU control path.
- Sits beside the core, muxed onto the data-memory port while busy_o is high.

---
 rtl/mem_block_mover_pkg.sv | 25 ++
 rtl/mem_block_mover.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_block_mover_pkg.sv
// ---------------------------------------------------------------------------
// mem_block_mover_pkg
// Shared types and default sizes for the data-memory block mover.
//   state_e : transfer sequencer states (IDLE, READ, WRITE, DONE)
//   mode_e  : transfer kind (MODE_COPY = memory to memory, MODE_FILL = constant)
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths (256 x 8 memory)
// ---------------------------------------------------------------------------
package mem_block_mover_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

endpackage

// File: rtl/mem_block_mover.sv
// ---------------------------------------------------------------------------
// mem_block_mover
// Bus initiator for the data memory. On a start request it either copies a
// block (read source byte, write destination byte, ascending) or fills a
// block with a constant. Owns the memory port while busy_o is high.
//
// Optional build macro: MEM_BLOCK_MOVER_CHECKSUM_EN adds checksum_o, the
// modulo-2**DATA_W sum of every byte written during the last transfer.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   start_i      in   request pulse, sampled only in IDLE
//   mode_i       in   0 = COPY, 1 = FILL (captured with start_i)
//   src_i        in   copy source base address
//   dst_i        in   destination base address
//   len_i        in   byte count, 0 = no transfer
//   fill_i       in   fill value
//   checksum_o   out  (macro only) sum of bytes written by last transfer
//   busy_o       out  high in READ and WRITE
//   done_o       out  one-cycle completion pulse
//   mem_we_o     out  memory write enable
//   mem_addr_o   out  memory address
//   mem_wdata_o  out  memory write data
//   mem_rdata_i  in   memory read data, combinational with mem_addr_o
// ---------------------------------------------------------------------------
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic [DATA_W-1:0] fill_i,
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            r_state;
  state_e            w_state_next;
  mode_e             r_mode;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_fill;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_wdata;

  // Byte that a WRITE cycle puts on the bus.
  assign w_wdata = (r_mode == MODE_FILL) ? r_fill : r_data;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0)
            w_state_next = DONE;
          else if (mode_e'(mode_i) == MODE_FILL)
            w_state_next = WRITE;
          else
            w_state_next = READ;
        end
      end
      READ:  w_state_next = WRITE;
      WRITE: begin
        // r_cnt still holds the pre-decrement count during this cycle.
        if (r_cnt == ADDR_W'(1))
          w_state_next = DONE;
        else if (r_mode == MODE_COPY)
          w_state_next = READ;
        else
          w_state_next = WRITE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_mode  <= MODE_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_fill  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_mode <= mode_e'(mode_i);
            r_src  <= src_i;
            r_dst  <= dst_i;
            r_cnt  <= len_i;
            r_fill <= fill_i;
          end
        end
        READ: r_data <= mem_rdata_i;
        WRITE: begin
          r_dst <= r_dst + ADDR_W'(1);
          if (r_mode == MODE_COPY)
            r_src <= r_src + ADDR_W'(1);
          r_cnt <= r_cnt - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_csum <= '0;
    else if (r_state == IDLE && start_i)
      r_csum <= '0;
    else if (r_state == WRITE)
      r_csum <= r_csum + w_wdata;
  end

  assign checksum_o = r_csum;
`endif

  // Moore output decode. The write strobe is additionally masked by rst_i so
  // the edge that aborts a transfer never commits a byte to memory.
  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (r_state)
      READ: begin
        busy_o     = 1'b1;
        mem_addr_o = r_src;
      end
      WRITE: begin
        busy_o      = 1'b1;
        mem_we_o    = ~rst_i;
        mem_addr_o  = r_dst;
        mem_wdata_o = w_wdata;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule
